// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) helpers, round constants,
// key-length encodings and the controller state type.
package aes_pkg;

  localparam logic [1:0] KEYLEN_128  = 2'd0;
  localparam logic [1:0] KEYLEN_192  = 2'd1;
  localparam logic [1:0] KEYLEN_256  = 2'd2;
  localparam logic [1:0] KEYLEN_RSVD = 2'd3;

  typedef enum logic [2:0] {
    S_NOKEY,
    S_KEYEXP,
    S_IDLE,
    S_ROUND,
    S_OUT
  } state_e;

  // Element 0 sits in the most significant byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      KEYLEN_128: return 4'd4;
      KEYLEN_192: return 4'd6;
      KEYLEN_256: return 4'd8;
      default:    return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      KEYLEN_128: return 4'd10;
      KEYLEN_192: return 4'd12;
      KEYLEN_256: return 4'd14;
      default:    return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. Byte n of a block is [127-8n -: 8], column-major.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         final_rnd,
  output logic [127:0] nxt
);

  logic [7:0]   shifted [16];
  logic [127:0] mixed;

  genvar gi;
  // Output byte (row r, column c) takes input byte (r, (c+r) mod 4).
  for (gi = 0; gi < 16; gi++) begin : g_sub_shift
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = 4 * ((C + R) % 4) + R;
    assign shifted[gi] = sbox(st[127-8*SRC -: 8]);
  end

  for (gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shifted[4*gi];
    assign a1 = shifted[4*gi+1];
    assign a2 = shifted[4*gi+2];
    assign a3 = shifted[4*gi+3];
    assign mixed[127-32*gi -: 32] = final_rnd ? {a0, a1, a2, a3} :
      {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  end

  assign nxt = mixed ^ rk;

endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128/192/256 encryptor: expands a key one word per clock
// into a round-key store, then encrypts blocks at one round per clock.
module aes_iter_encrypt
  import aes_pkg::*;
#(
  parameter  int MAX_NK = 8,
  localparam int KEY_W  = 32 * MAX_NK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [1:0]       key_len,
  input  logic [KEY_W-1:0] key,
  output logic             key_ok,
  output logic             key_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data
);

  localparam int MAX_NR = MAX_NK + 6;
  localparam int NW     = 4 * (MAX_NR + 1);
  localparam int IDX_W  = $clog2(NW);

  state_e           state_q, state_d;
  logic [3:0]       nk_q, nk_d, nr_q, nr_d, rnd_q, rnd_d, rc_q, rc_d;
  logic [2:0]       j_q, j_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [127:0]     st_q, st_d, out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, key_ok_q, key_ok_d, key_err_q, key_err_d;

  logic [31:0]      w_mem [NW];
  logic             w_we, key_load, ld_bad, final_rnd;
  logic [3:0]       ld_nk;
  logic [31:0]      prev_word, back_word, temp_word, new_word;
  logic [IDX_W-1:0] rk_base, last_idx;
  logic [127:0]     rk, round_out;

  assign ld_nk  = nk_of(key_len);
  assign ld_bad = (key_len == KEYLEN_RSVD) || (int'(ld_nk) > MAX_NK);

  assign key_ready = (state_q == S_NOKEY) || (state_q == S_IDLE);
  assign in_ready  = (state_q == S_IDLE) && !key_valid;
  assign key_ok    = key_ok_q;
  assign key_err   = key_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Round key 0 is read while idle so the whitening XOR happens at accept.
  assign rk_base   = (state_q == S_ROUND) ? IDX_W'({rnd_q, 2'b00}) : '0;
  assign rk        = {w_mem[rk_base], w_mem[rk_base + IDX_W'(1)],
                      w_mem[rk_base + IDX_W'(2)], w_mem[rk_base + IDX_W'(3)]};
  assign final_rnd = (rnd_q == nr_q);
  assign last_idx  = IDX_W'({nr_q, 2'b11});

  aes_round_comb u_round (
    .st        (st_q),
    .rk        (rk),
    .final_rnd (final_rnd),
    .nxt       (round_out)
  );

  // j_q tracks i mod Nk and rc_q tracks i / Nk, avoiding dividers.
  assign prev_word = w_mem[i_q - IDX_W'(1)];
  assign back_word = w_mem[i_q - IDX_W'(nk_q)];
  always_comb begin
    temp_word = prev_word;
    if (j_q == 3'd0) begin
      temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon(rc_q), 24'h0};
    end else if (nk_q == 4'd8 && j_q == 3'd4) begin
      temp_word = sub_word(prev_word);
    end
  end
  assign new_word = back_word ^ temp_word;

  always_ff @(posedge clk) begin
    if (key_load) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (k < int'(ld_nk)) w_mem[k] <= key[KEY_W-1-32*k -: 32];
      end
    end else if (w_we) begin
      w_mem[i_q] <= new_word;
    end
  end

  always_comb begin
    state_d     = state_q;
    nk_d        = nk_q;
    nr_d        = nr_q;
    rnd_d       = rnd_q;
    rc_d        = rc_q;
    j_d         = j_q;
    i_d         = i_q;
    st_d        = st_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    key_ok_d    = key_ok_q;
    key_err_d   = 1'b0;
    w_we        = 1'b0;
    key_load    = 1'b0;
    case (state_q)
      S_NOKEY, S_IDLE: begin
        if (key_valid) begin
          key_ok_d = 1'b0;
          if (ld_bad) begin
            key_err_d = 1'b1;
            state_d   = S_NOKEY;
          end else begin
            key_load = 1'b1;
            nk_d     = ld_nk;
            nr_d     = nr_of(key_len);
            i_d      = IDX_W'(ld_nk);
            j_d      = 3'd0;
            rc_d     = 4'd1;
            state_d  = S_KEYEXP;
          end
        end else if (state_q == S_IDLE && in_valid) begin
          st_d    = in_data ^ rk;
          rnd_d   = 4'd1;
          state_d = S_ROUND;
        end
      end
      S_KEYEXP: begin
        w_we = 1'b1;
        if (i_q == last_idx) begin
          key_ok_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          i_d = i_q + IDX_W'(1);
          if ({1'b0, j_q} == nk_q - 4'd1) begin
            j_d  = 3'd0;
            rc_d = rc_q + 4'd1;
          end else begin
            j_d = j_q + 3'd1;
          end
        end
      end
      S_ROUND: begin
        st_d = round_out;
        if (final_rnd) begin
          out_data_d  = round_out;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_NOKEY;
      nk_q        <= '0;
      nr_q        <= '0;
      rnd_q       <= '0;
      rc_q        <= '0;
      j_q         <= '0;
      i_q         <= '0;
      st_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      key_ok_q    <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nk_q        <= nk_d;
      nr_q        <= nr_d;
      rnd_q       <= rnd_d;
      rc_q        <= rc_d;
      j_q         <= j_d;
      i_q         <= i_d;
      st_q        <= st_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      key_ok_q    <= key_ok_d;
      key_err_q   <= key_err_d;
    end
  end

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Bench for aes_iter_encrypt: FIPS-197 vectors through a scoreboard, plus
// backpressure, bad key length, key change and asynchronous reset sequences.
module tb_aes_iter_encrypt;

  localparam int KEY_W = 256;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_valid = 1'b0;
  logic             key_ready;
  logic [1:0]       key_len = 2'd0;
  logic [KEY_W-1:0] key = '0;
  logic             key_ok, key_err;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [127:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [127:0]     out_data;

  always #5 clk = ~clk;

  aes_iter_encrypt #(.MAX_NK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_len   (key_len),
    .key       (key),
    .key_ok    (key_ok),
    .key_err   (key_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    logic [127:0] ct;
    int           lat;
    int           kexp;
  } vec_t;

  typedef struct {
    logic [127:0] ct;
    int           lat;
  } exp_t;

  vec_t vecs [3];
  exp_t sb [$];
  int   total = 0;
  int   bad = 0;
  int   n_xfer = 0;
  int   cyc_cnt = 0;
  int   acc_cyc = 0;
  logic ov_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard side: latency on the rising edge of out_valid, data on transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc_cnt;
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("unexpected_out", 128'(out_valid), 128'(0));
        else chk("latency", 128'(cyc_cnt - acc_cyc), 128'(sb[0].lat));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_xfer", 128'(out_valid), 128'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", out_data, e.ct);
          n_xfer++;
          $display("xfer %0d: out_data=%h expected=%h", n_xfer, out_data, e.ct);
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_key(input logic [1:0] len, input logic [255:0] k);
    key_valid = 1'b1;
    key_len   = len;
    key       = k;
    cyc();
    key_valid = 1'b0;
    key_len   = 2'd3;
    key       = '1;
  endtask

  task automatic wait_key_ok(input int nexp);
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (key_ok) break;
      n++;
    end
    chk("kexp_cycles", 128'(n), 128'(nexp));
    cyc();
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] ct, input int lat,
                      output int waited);
    exp_t e;
    e.ct = ct;
    e.lat = lat;
    in_valid = 1'b1;
    in_data  = pt;
    sb.push_back(e);
    waited = 0;
    while (waited < 200) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
    end
    chk("accept", 128'(in_ready), 128'(1));
    cyc();
    in_valid = 1'b0;
    in_data  = '1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      cyc();
      n++;
    end
    chk("drain", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, x, cnt;
    vecs[0] = '{2'd0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 11, 40};
    vecs[1] = '{2'd1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, 13, 46};
    vecs[2] = '{2'd2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, 15, 52};

    // Reset values
    cyc(2);
    @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 128'(1));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_key_ok", 128'(key_ok), 128'(0));
    chk("rst_key_err", 128'(key_err), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    cyc();
    rst_n = 1'b1;
    cyc();

    // FIPS-197 C.1 / C.2 / C.3
    for (int v = 0; v < 3; v++) begin
      load_key(vecs[v].len, vecs[v].key);
      wait_key_ok(vecs[v].kexp);
      send(PT, vecs[v].ct, vecs[v].lat, w);
      drain();
    end

    // Backpressure under the 256-bit key
    out_ready = 1'b0;
    send(PT, vecs[2].ct, vecs[2].lat, w);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_valid", 128'(out_valid), 128'(1));
    x = n_xfer;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_data", out_data, vecs[2].ct);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_key_ready", 128'(key_ready), 128'(0));
    end
    cyc();
    out_ready = 1'b1;
    cyc(5);
    chk("bp_xfers", 128'(n_xfer - x), 128'(1));
    chk("bp_valid_low", 128'(out_valid), 128'(0));

    // Reserved key length with data pending
    in_valid  = 1'b1;
    in_data   = PT;
    key_valid = 1'b1;
    key_len   = 2'd3;
    cyc();
    key_valid = 1'b0;
    key_len   = 2'd0;
    @(negedge clk);
    chk("err_pulse", 128'(key_err), 128'(1));
    chk("err_key_ok", 128'(key_ok), 128'(0));
    chk("err_in_ready", 128'(in_ready), 128'(0));
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (key_err) cnt++;
      if (in_ready) cnt += 100;
    end
    chk("err_single_no_accept", 128'(cnt), 128'(0));
    cyc();
    in_valid = 1'b0;

    // Key and data together: key wins, block waits for expansion
    key_valid = 1'b1;
    key_len   = vecs[0].len;
    key       = vecs[0].key;
    in_valid  = 1'b1;
    in_data   = PT;
    begin
      exp_t e;
      e.ct = vecs[0].ct;
      e.lat = vecs[0].lat;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("both_in_ready", 128'(in_ready), 128'(0));
    chk("both_key_ready", 128'(key_ready), 128'(1));
    cyc();
    key_valid = 1'b0;
    key_len   = 2'd3;
    w = 0;
    while (w < 200) begin
      @(negedge clk);
      if (in_ready) break;
      w++;
    end
    chk("data_wait", 128'(w), 128'(40));
    cyc();
    in_valid = 1'b0;
    drain();

    // Key change from idle replaces the schedule
    load_key(vecs[2].len, vecs[2].key);
    wait_key_ok(52);
    send(PT, vecs[2].ct, vecs[2].lat, w);
    drain();

    // Asynchronous reset mid-round
    send(PT, vecs[2].ct, vecs[2].lat, w);
    cyc(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_out_valid", 128'(out_valid), 128'(0));
    chk("rr_key_ok", 128'(key_ok), 128'(0));
    chk("rr_key_ready", 128'(key_ready), 128'(1));
    sb.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc();

    // Asynchronous reset mid-expansion
    load_key(vecs[2].len, vecs[2].key);
    cyc(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rk_key_ok", 128'(key_ok), 128'(0));
    chk("rk_key_ready", 128'(key_ready), 128'(1));
    cyc(2);
    rst_n = 1'b1;
    cyc();

    load_key(vecs[0].len, vecs[0].key);
    wait_key_ok(vecs[0].kexp);
    send(PT, vecs[0].ct, vecs[0].lat, w);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
